// File: rtl/cv32e40s_rvfi_obi_sched.sv
// In-order tracker pairing OBI data address phases with their responses until WB retires them.
// Optional sticky protocol checks are compiled in with CV32E40S_RVFI_OBI_CHK_EN.
module cv32e40s_rvfi_obi_sched #(
  parameter  int unsigned DEPTH     = 4,
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 obi_req,
  input  logic                 obi_gnt,
  input  logic [31:0]          obi_addr,
  input  logic                 obi_we,
  input  logic [3:0]           obi_be,
  input  logic [31:0]          obi_wdata,
  input  logic                 obi_rvalid,
  input  logic [31:0]          obi_rdata,
  input  logic                 obi_err,
  input  logic                 wb_pop,
  output logic                 out_valid,
  output logic [31:0]          out_addr,
  output logic                 out_we,
  output logic [3:0]           out_be,
  output logic [31:0]          out_wdata,
  output logic [31:0]          out_rdata,
  output logic                 out_err,
  output logic [PTR_WIDTH:0]   cnt,
  output logic                 full,
  output logic                 empty,
  output logic [2:0]           chk_err
);

  typedef enum logic [1:0] {
    ENT_FREE      = 2'd0,
    ENT_ISSUED    = 2'd1,
    ENT_RESPONDED = 2'd2
  } ent_state_e;

  localparam logic [PTR_WIDTH:0]   DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

  ent_state_e            state_q [DEPTH];
  ent_state_e            state_d [DEPTH];
  logic [31:0]           addr_q  [DEPTH];
  logic                  we_q    [DEPTH];
  logic [3:0]            be_q    [DEPTH];
  logic [31:0]           wdata_q [DEPTH];
  logic [31:0]           rdata_q [DEPTH];
  logic                  err_q   [DEPTH];

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rsp_ptr_q, rsp_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    cnt_q, cnt_d;

  logic                  accept;
  logic                  pop_ok;
  logic                  push_en;
  logic                  rsp_en;

  assign accept    = obi_req & obi_gnt;
  assign out_valid = (state_q[rd_ptr_q] == ENT_RESPONDED);
  assign pop_ok    = wb_pop & out_valid;
  assign full      = (cnt_q == DEPTH_CNT);
  assign empty     = (cnt_q == '0);
  // A pop in the same cycle frees the slot a full tracker would otherwise refuse.
  assign push_en   = accept & (~full | pop_ok);
  assign rsp_en    = obi_rvalid & (state_q[rsp_ptr_q] == ENT_ISSUED);

  assign cnt       = cnt_q;
  assign out_addr  = addr_q[rd_ptr_q];
  assign out_we    = we_q[rd_ptr_q];
  assign out_be    = be_q[rd_ptr_q];
  assign out_wdata = wdata_q[rd_ptr_q];
  assign out_rdata = rdata_q[rd_ptr_q];
  assign out_err   = err_q[rd_ptr_q];

  // Later assignments win: a push into the slot being popped must leave it ISSUED.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
    end
    wr_ptr_d  = wr_ptr_q;
    rsp_ptr_d = rsp_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;

    if (pop_ok) begin
      state_d[rd_ptr_q] = ENT_FREE;
      rd_ptr_d          = rd_ptr_q + PTR_ONE;
    end
    if (rsp_en) begin
      state_d[rsp_ptr_q] = ENT_RESPONDED;
      rsp_ptr_d          = rsp_ptr_q + PTR_ONE;
    end
    if (push_en) begin
      state_d[wr_ptr_q] = ENT_ISSUED;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end

    case ({push_en, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ENT_FREE;
      end
      wr_ptr_q  <= '0;
      rsp_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rsp_ptr_q <= rsp_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Payload storage; fields only change on their own capture event, so the head stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        we_q[i]    <= 1'b0;
        be_q[i]    <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
        err_q[i]   <= 1'b0;
      end
    end else begin
      if (push_en) begin
        addr_q[wr_ptr_q]  <= obi_addr;
        we_q[wr_ptr_q]    <= obi_we;
        be_q[wr_ptr_q]    <= obi_be;
        wdata_q[wr_ptr_q] <= obi_wdata;
      end
      if (rsp_en) begin
        rdata_q[rsp_ptr_q] <= obi_rdata;
        err_q[rsp_ptr_q]   <= obi_err;
      end
    end
  end

`ifdef CV32E40S_RVFI_OBI_CHK_EN
  logic [2:0] chk_err_q, chk_err_d;
  logic       chk_overflow;
  logic       chk_underflow;
  logic       chk_spurious;

  assign chk_overflow  = accept & full & ~pop_ok;
  assign chk_underflow = wb_pop & ~out_valid;
  assign chk_spurious  = obi_rvalid & (state_q[rsp_ptr_q] != ENT_ISSUED);
  assign chk_err_d     = chk_err_q | {chk_spurious, chk_underflow, chk_overflow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= '0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 3'b000;
`endif

endmodule

// File: tb/tb_cv32e40s_rvfi_obi_sched.sv
// Directed self-checking bench for cv32e40s_rvfi_obi_sched (DEPTH=4); expects chk_err
// only when CV32E40S_RVFI_OBI_CHK_EN is defined for both bench and design.
module tb_cv32e40s_rvfi_obi_sched;

  logic        clk;
  logic        rst_n;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err, wb_pop;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [3:0]  obi_be;
  logic        out_valid, out_we, out_err, full, empty;
  logic [31:0] out_addr, out_wdata, out_rdata;
  logic [3:0]  out_be;
  logic [2:0]  cnt;
  logic [2:0]  chk_err;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef CV32E40S_RVFI_OBI_CHK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  cv32e40s_rvfi_obi_sched #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .obi_req    (obi_req),
    .obi_gnt    (obi_gnt),
    .obi_addr   (obi_addr),
    .obi_we     (obi_we),
    .obi_be     (obi_be),
    .obi_wdata  (obi_wdata),
    .obi_rvalid (obi_rvalid),
    .obi_rdata  (obi_rdata),
    .obi_err    (obi_err),
    .wb_pop     (wb_pop),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_we     (out_we),
    .out_be     (out_be),
    .out_wdata  (out_wdata),
    .out_rdata  (out_rdata),
    .out_err    (out_err),
    .cnt        (cnt),
    .full       (full),
    .empty      (empty),
    .chk_err    (chk_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Driver tasks
  task automatic idle();
    obi_req = 0; obi_gnt = 0; obi_addr = '0; obi_we = 0; obi_be = '0; obi_wdata = '0;
    obi_rvalid = 0; obi_rdata = '0; obi_err = 0; wb_pop = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd);
    obi_req = 1; obi_gnt = 1; obi_addr = a; obi_we = we; obi_be = be; obi_wdata = wd;
  endtask

  task automatic no_push();
    obi_req = 0; obi_gnt = 0;
  endtask

  task automatic rsp(input logic [31:0] rd, input logic e);
    obi_rvalid = 1; obi_rdata = rd; obi_err = e;
  endtask

  task automatic no_rsp();
    obi_rvalid = 0; obi_err = 0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    tests_run++;
    if ({out_valid, empty, full, cnt, chk_err} !== {1'b0, 1'b1, 1'b0, 3'd0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_flags: got v=%b e=%b f=%b c=%0d k=%b required 0 1 0 0 000",
               out_valid, empty, full, cnt, chk_err);
    end
    tests_run++;
    if ({out_addr, out_rdata, out_wdata, out_be, out_we, out_err} !== 78'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h rdata=%h wdata=%h required zeros",
               out_addr, out_rdata, out_wdata);
    end
    do_reset();
  endtask

  task automatic test_single_load();
    do_reset();
    push(32'h100, 1'b0, 4'hF, 32'h0);
    step();
    no_push();
    tests_run++;
    if (out_valid !== 1'b0 || cnt !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_issued: got v=%b cnt=%0d required v=0 cnt=1", out_valid, cnt);
    end
    rsp(32'hDEADBEEF, 1'b0);
    step();
    no_rsp();
    tests_run++;
    if (out_valid !== 1'b1 || out_rdata !== 32'hDEADBEEF || out_addr !== 32'h100 || out_be !== 4'hF) begin
      tests_failed++;
      $display("FAIL single_resp: got v=%b rdata=%h addr=%h be=%h required 1 deadbeef 100 f",
               out_valid, out_rdata, out_addr, out_be);
    end
    wb_pop = 1;
    step();
    wb_pop = 0;
    tests_run++;
    if (empty !== 1'b1 || cnt !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pop: got e=%b cnt=%0d v=%b required 1 0 0", empty, cnt, out_valid);
    end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] exp_q[$];
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 32'h10 * (i + 1);
      push(a, 1'b0, 4'hF, 32'h0);
      exp_q.push_back(a);
      step();
    end
    no_push();
    tests_run++;
    if (full !== 1'b1 || cnt !== 3'd4 || chk_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL fill_full: got f=%b cnt=%0d k=%b required 1 4 000", full, cnt, chk_err);
    end
    push(32'h200, 1'b0, 4'hF, 32'h0);
    step();
    no_push();
    tests_run++;
    if (cnt !== 3'd4 || chk_err[0] !== CHK_ON) begin
      tests_failed++;
      $display("FAIL fill_overflow: got cnt=%0d ovf=%b required 4 %b", cnt, chk_err[0], CHK_ON);
    end
    for (int i = 0; i < 4; i++) begin
      rsp(32'hA0 + i, 1'b0);
      step();
    end
    no_rsp();
    for (int i = 0; i < 4; i++) begin
      a = exp_q.pop_front();
      tests_run++;
      if (out_valid !== 1'b1 || out_addr !== a || out_rdata !== 32'hA0 + i) begin
        tests_failed++;
        $display("FAIL fill_drain%0d: got v=%b addr=%h rdata=%h required 1 %h %h",
                 i, out_valid, out_addr, out_rdata, a, 32'hA0 + i);
      end
      wb_pop = 1;
      step();
      wb_pop = 0;
    end
    tests_run++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_dropped: got e=%b v=%b required 1 0", empty, out_valid);
    end
  endtask

  // Push, respond and pop staggered by one cycle each so six entries cycle through four slots.
  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) push(32'h300 + c * 4, 1'b0, 4'hF, 32'h0); else no_push();
      if (c >= 1 && c < 7) rsp(32'h5000 + (c - 1), 1'b0); else no_rsp();
      if (c >= 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_addr !== 32'h300 + (c - 2) * 4 || out_rdata !== 32'h5000 + (c - 2)) begin
          tests_failed++;
          $display("FAIL wrap_head%0d: got v=%b addr=%h rdata=%h required 1 %h %h", c,
                   out_valid, out_addr, out_rdata, 32'h300 + (c - 2) * 4, 32'h5000 + (c - 2));
        end
        wb_pop = 1;
      end
      step();
      wb_pop = 0;
      tests_run++;
      if (cnt > 3'd4) begin
        tests_failed++;
        $display("FAIL wrap_cnt%0d: got %0d required <=4", c, cnt);
      end
    end
    idle();
    tests_run++;
    if (empty !== 1'b1 || chk_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL wrap_end: got e=%b k=%b required 1 000", empty, chk_err);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q[$];
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'h10 * (i + 1), 1'b0, 4'hF, 32'h0);
      exp_q.push_back(32'h10 * (i + 1));
      step();
    end
    no_push();
    rsp(32'h77, 1'b0);
    step();
    no_rsp();
    void'(exp_q.pop_front());
    push(32'h500, 1'b0, 4'hF, 32'h0);
    wb_pop = 1;
    exp_q.push_back(32'h500);
    step();
    no_push();
    wb_pop = 0;
    tests_run++;
    if (cnt !== 3'd4 || full !== 1'b1 || chk_err[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL fullpp_state: got cnt=%0d f=%b ovf=%b required 4 1 0", cnt, full, chk_err[0]);
    end
    for (int i = 0; i < 4; i++) begin
      rsp(32'hB0 + i, 1'b0);
      step();
    end
    no_rsp();
    for (int i = 0; i < 4; i++) begin
      a = exp_q.pop_front();
      tests_run++;
      if (out_valid !== 1'b1 || out_addr !== a) begin
        tests_failed++;
        $display("FAIL fullpp_drain%0d: got v=%b addr=%h required 1 %h", i, out_valid, out_addr, a);
      end
      wb_pop = 1;
      step();
      wb_pop = 0;
    end
    tests_run++;
    if (empty !== 1'b1 || chk_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL fullpp_end: got e=%b k=%b required 1 000", empty, chk_err);
    end
  endtask

  task automatic test_store_err();
    do_reset();
    push(32'h600, 1'b1, 4'h3, 32'hCAFEF00D);
    step();
    no_push();
    rsp(32'h0, 1'b1);
    step();
    no_rsp();
    tests_run++;
    if (out_valid !== 1'b1 || out_we !== 1'b1 || out_err !== 1'b1 ||
        out_wdata !== 32'hCAFEF00D || out_be !== 4'h3 || out_addr !== 32'h600) begin
      tests_failed++;
      $display("FAIL store_err: got v=%b we=%b err=%b wdata=%h be=%h addr=%h required 1 1 1 cafef00d 3 600",
               out_valid, out_we, out_err, out_wdata, out_be, out_addr);
    end
    wb_pop = 1;
    step();
    wb_pop = 0;
  endtask

  task automatic test_checks_and_async_reset();
    do_reset();
    rsp(32'h1, 1'b0);
    step();
    no_rsp();
    tests_run++;
    if (chk_err !== {CHK_ON, 2'b00} || cnt !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_rvalid: got k=%b cnt=%0d v=%b required %b 0 0", chk_err, cnt,
               out_valid, {CHK_ON, 2'b00});
    end
    wb_pop = 1;
    step();
    wb_pop = 0;
    tests_run++;
    if (chk_err !== {CHK_ON, CHK_ON, 1'b0} || cnt !== 3'd0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL underflow: got k=%b cnt=%0d e=%b required %b 0 1", chk_err, cnt, empty,
               {CHK_ON, CHK_ON, 1'b0});
    end
    do_reset();
    push(32'h700, 1'b0, 4'hF, 32'h0);
    step();
    push(32'h704, 1'b0, 4'hF, 32'h0);
    rsp(32'h99, 1'b0);
    step();
    idle();
    tests_run++;
    if (out_valid !== 1'b1 || cnt !== 3'd2) begin
      tests_failed++;
      $display("FAIL midtraffic_pre: got v=%b cnt=%0d required 1 2", out_valid, cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, empty, full, cnt, chk_err, out_addr, out_rdata} !==
        {1'b0, 1'b1, 1'b0, 3'd0, 3'b000, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b e=%b f=%b cnt=%0d k=%b addr=%h rdata=%h required 0 1 0 0 000 0 0",
               out_valid, empty, full, cnt, chk_err, out_addr, out_rdata);
    end
    step();
    rst_n = 1'b1;
    rsp(32'h98, 1'b0);
    step();
    no_rsp();
    tests_run++;
    if (chk_err !== {CHK_ON, 2'b00} || out_valid !== 1'b0 || cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL late_rvalid: got k=%b v=%b cnt=%0d required %b 0 0", chk_err, out_valid,
               cnt, {CHK_ON, 2'b00});
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_single_load();
    test_fill_overflow();
    test_wrap();
    test_full_push_pop();
    test_store_err();
    test_checks_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
